xpb_table_writer: RTL and testbench

Runtime generator for one XPB lookup table. Given a base value B and modulus N, it computes entries k*B mod N for k = 0..2^DIGIT_W-1 by repeated limb-serial modular addition. It writes each entry into an external table RAM through a one-cycle write strobe. It is the producing end of the table interface that the modular-square datapath reads by DIGIT_W-bit index, so tables can be built for a new modulus without regenerating constants.

---
 rtl/xpb_pkg.sv | 18 +
 rtl/xpb_limb_addsub.sv | 30 +++
 rtl/xpb_table_writer.sv | 218 +++++++++++++++++++++
 tb/tb_xpb_table_writer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_pkg.sv
// Shared constants and FSM encoding for the XPB table generator.
package xpb_pkg;

    localparam int BIT_LEN    = 1024;
    localparam int DIGIT_W    = 5;
    localparam int LIMB_W     = 64;
    localparam int NUM_LIMBS  = BIT_LEN / LIMB_W;
    localparam int LIMB_IDX_W = $clog2(NUM_LIMBS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } xpb_state_e;

endpackage

// File: rtl/xpb_limb_addsub.sv
// One limb of the modular step: s = a + b + cin, d = s - n - bin, with carry/borrow out.
module xpb_limb_addsub #(
    parameter int LIMB_W = xpb_pkg::LIMB_W
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic [LIMB_W-1:0] n,
    input  logic              carry_in,
    input  logic              borrow_in,
    output logic [LIMB_W-1:0] sum,
    output logic [LIMB_W-1:0] diff,
    output logic              carry_out,
    output logic              borrow_out
);

    logic [LIMB_W:0] sum_ext_s;
    logic [LIMB_W:0] diff_ext_s;

    // Widened add then subtract; the top bit of the subtraction is the borrow.
    always_comb begin
        sum_ext_s  = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, carry_in};
        diff_ext_s = {1'b0, sum_ext_s[LIMB_W-1:0]} - {1'b0, n} - {{LIMB_W{1'b0}}, borrow_in};
    end

    assign sum        = sum_ext_s[LIMB_W-1:0];
    assign carry_out  = sum_ext_s[LIMB_W];
    assign diff       = diff_ext_s[LIMB_W-1:0];
    assign borrow_out = diff_ext_s[LIMB_W];

endmodule

// File: rtl/xpb_table_writer.sv
// Builds the k*B mod N table (k = 0..2^DIGIT_W-1) with one limb-serial add/sub unit
// and streams each entry out through a single-cycle write strobe.
module xpb_table_writer #(
    parameter int BIT_LEN = xpb_pkg::BIT_LEN,
    parameter int DIGIT_W = xpb_pkg::DIGIT_W,
    parameter int LIMB_W  = xpb_pkg::LIMB_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BIT_LEN-1:0] base_in,
    input  logic [BIT_LEN-1:0] mod_in,
    output logic               busy,
    output logic               done,
    output logic               wr_en,
    output logic [DIGIT_W-1:0] wr_addr,
    output logic [BIT_LEN-1:0] wr_data
);
    import xpb_pkg::*;

    localparam int LIMBS = BIT_LEN / LIMB_W;
    localparam int IDX_W = (LIMBS > 1) ? $clog2(LIMBS) : 1;
    localparam logic [IDX_W-1:0]   LAST_LIMB = IDX_W'(LIMBS - 1);
    localparam logic [IDX_W-1:0]   ONE_LIMB  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [DIGIT_W-1:0] LAST_K    = {DIGIT_W{1'b1}};
    localparam logic [DIGIT_W-1:0] ONE_K     = {{(DIGIT_W-1){1'b0}}, 1'b1};

    typedef logic [LIMBS-1:0][LIMB_W-1:0] limbs_t;

    xpb_state_e         state_r, next_state_s;
    limbs_t             base_r, mod_r, acc_r, sum_r, diff_r;
    limbs_t             sum_full_s, diff_full_s, sel_s;
    logic               carry_r, borrow_r;
    logic [IDX_W-1:0]   limb_r;
    logic [DIGIT_W-1:0] k_r;
    logic               last_limb_s;

    logic [LIMB_W-1:0]  limb_sum_s, limb_diff_s;
    logic               limb_carry_s, limb_borrow_s;

    logic               busy_r, done_r, wr_en_r;
    logic [DIGIT_W-1:0] wr_addr_r;
    limbs_t             wr_data_r;
    logic               busy_nxt_s, done_nxt_s, wr_en_nxt_s;
    logic [DIGIT_W-1:0] wr_addr_nxt_s;
    limbs_t             wr_data_nxt_s;

    xpb_limb_addsub #(.LIMB_W(LIMB_W)) u_addsub (
        .a          (acc_r[limb_r]),
        .b          (base_r[limb_r]),
        .n          (mod_r[limb_r]),
        .carry_in   (carry_r),
        .borrow_in  (borrow_r),
        .sum        (limb_sum_s),
        .diff       (limb_diff_s),
        .carry_out  (limb_carry_s),
        .borrow_out (limb_borrow_s)
    );

    assign last_limb_s = (limb_r == LAST_LIMB);

    // Final-limb merge: the entry is resolved on the last ACCUM edge so WRITE can present it.
    // A carry out or no final borrow both mean acc+B >= N, so the difference is the residue.
    always_comb begin
        sum_full_s            = sum_r;
        diff_full_s           = diff_r;
        sum_full_s[LIMBS-1]   = limb_sum_s;
        diff_full_s[LIMBS-1]  = limb_diff_s;
        if (limb_carry_s || !limb_borrow_s) begin
            sel_s = diff_full_s;
        end else begin
            sel_s = sum_full_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = CLEAR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CLEAR: next_state_s = ACCUM;
            ACCUM: begin
                if (last_limb_s) begin
                    next_state_s = WRITE;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            WRITE: begin
                if (k_r == LAST_K) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = ACCUM;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, aligned with the state they enter.
    always_comb begin
        busy_nxt_s    = (next_state_s != IDLE);
        done_nxt_s    = (next_state_s == DONE);
        wr_en_nxt_s   = (next_state_s == CLEAR) || (next_state_s == WRITE);
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        if ((state_r == IDLE) && start) begin
            wr_addr_nxt_s = '0;
            wr_data_nxt_s = '0;
        end else if ((state_r == ACCUM) && last_limb_s) begin
            wr_addr_nxt_s = k_r;
            wr_data_nxt_s = sel_s;
        end else begin
            wr_addr_nxt_s = wr_addr_r;
            wr_data_nxt_s = wr_data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
        end else begin
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
        end
    end

    // Operand capture, limb-serial accumulation and entry index.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_r   <= '0;
            mod_r    <= '0;
            acc_r    <= '0;
            sum_r    <= '0;
            diff_r   <= '0;
            carry_r  <= 1'b0;
            borrow_r <= 1'b0;
            limb_r   <= '0;
            k_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        base_r   <= base_in;
                        mod_r    <= mod_in;
                        acc_r    <= '0;
                        carry_r  <= 1'b0;
                        borrow_r <= 1'b0;
                        limb_r   <= '0;
                    end
                end
                CLEAR: begin
                    k_r      <= ONE_K;
                    carry_r  <= 1'b0;
                    borrow_r <= 1'b0;
                    limb_r   <= '0;
                end
                ACCUM: begin
                    sum_r[limb_r]  <= limb_sum_s;
                    diff_r[limb_r] <= limb_diff_s;
                    carry_r        <= limb_carry_s;
                    borrow_r       <= limb_borrow_s;
                    if (last_limb_s) begin
                        acc_r  <= sel_s;
                        limb_r <= '0;
                    end else begin
                        limb_r <= limb_r + ONE_LIMB;
                    end
                end
                WRITE: begin
                    carry_r  <= 1'b0;
                    borrow_r <= 1'b0;
                    limb_r   <= '0;
                    if (k_r != LAST_K) begin
                        k_r <= k_r + ONE_K;
                    end
                end
                DONE: begin
                    limb_r <= '0;
                end
                default: begin
                    limb_r <= '0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;

endmodule

// File: tb/tb_xpb_table_writer.sv
// Scoreboard bench for xpb_table_writer: expected entries are queued per job and
// a negedge monitor pops and compares them against every wr_en pulse.
module tb_xpb_table_writer;

    localparam int BW    = 1024;
    localparam int DW    = 5;
    localparam int DEPTH = 32;

    typedef struct packed {
        logic [DW-1:0] addr;
        logic [BW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [BW-1:0] base_in, mod_in;
    logic          busy, done, wr_en;
    logic [DW-1:0] wr_addr;
    logic [BW-1:0] wr_data;

    exp_t          sb_q[$];
    logic [BW-1:0] mem [DEPTH];
    int            checks   = 0;
    int            failures = 0;
    int            pulses   = 0;

    xpb_table_writer #(.BIT_LEN(BW), .DIGIT_W(DW), .LIMB_W(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .base_in (base_in),
        .mod_in  (mod_in),
        .busy    (busy),
        .done    (done),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic check_bits(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got(low256)=%0h exp(low256)=%0h", name, got[255:0], exp[255:0]);
        end
    endtask

    function automatic logic [BW-1:0] rand_wide();
        logic [BW-1:0] r;
        for (int w = 0; w < BW / 32; w++) begin
            r[w*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    // Reference: running sum reduced by a conditional subtract, in one wide step.
    task automatic push_expect(input logic [BW-1:0] b, input logic [BW-1:0] n);
        logic [BW:0] a;
        exp_t        e;
        a = '0;
        for (int k = 0; k < DEPTH; k++) begin
            e.addr = DW'(k);
            e.data = a[BW-1:0];
            sb_q.push_back(e);
            a = a + {1'b0, b};
            if (a >= {1'b0, n}) begin
                a = a - {1'b0, n};
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                pulses++;
                mem[wr_addr] = wr_data;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d", wr_addr);
                end else begin
                    e = sb_q.pop_front();
                    check_int("wr_addr", int'(wr_addr), int'(e.addr));
                    check_bits("wr_data", wr_data, e.data);
                end
            end
        end
    endtask

    task automatic run_job(input logic [BW-1:0] b, input logic [BW-1:0] n,
                           input int disturb_at, input int reset_at);
        int done_at;
        int busy_cnt;
        int pulses_at_abort;
        bit aborted;
        push_expect(b, n);
        pulses = 0;
        @(posedge clk); #1;
        base_in = b;
        mod_in  = n;
        start   = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        done_at  = 0;
        busy_cnt = 0;
        aborted  = 1'b0;
        for (int i = 1; i <= 600 && done_at == 0 && !aborted; i++) begin
            if (i == disturb_at) begin
                start   = 1'b1;
                base_in = ~b;
                mod_in  = n ^ {{(BW-1){1'b0}}, 1'b1};
            end else begin
                start = 1'b0;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                sb_q.delete();
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check_int("rst_busy", int'(busy), 0);
                check_int("rst_done", int'(done), 0);
                check_int("rst_wr_en", int'(wr_en), 0);
                check_int("rst_wr_addr", int'(wr_addr), 0);
                check_bits("rst_wr_data", wr_data, '0);
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                if (busy) busy_cnt++;
                if (done) done_at = i;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        if (aborted) begin
            pulses_at_abort = pulses;
            repeat (60) @(negedge clk);
            check_int("no_writes_after_reset", pulses, pulses_at_abort);
            check_int("busy_after_reset", int'(busy), 0);
        end else begin
            check_int("done_cycle", done_at, 529);
            check_int("busy_cycles", busy_cnt, 529);
            check_int("wr_en_pulses", pulses, DEPTH);
            check_int("scoreboard_empty", sb_q.size(), 0);
            @(posedge clk); #1;
            @(negedge clk);
            check_int("busy_after_done", int'(busy), 0);
            check_int("done_after_done", int'(done), 0);
        end
    endtask

    initial begin
        logic [BW-1:0] all1, b, n;
        all1    = '1;
        reset   = 1'b1;
        start   = 1'b0;
        base_in = '0;
        mod_in  = '0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_wr_en", int'(wr_en), 0);
        check_int("reset_wr_addr", int'(wr_addr), 0);
        check_bits("reset_wr_data", wr_data, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // B=1 over the all-ones modulus: entry k is simply k.
        run_job({{(BW-1){1'b0}}, 1'b1}, all1, 0, 0);
        check_bits("b1_addr0", mem[0], '0);
        check_bits("b1_addr5", mem[5], BW'(5));
        check_bits("b1_addr31", mem[31], BW'(31));

        // N=17, B=16: wraps and takes the sum path.
        run_job(BW'(16), BW'(17), 0, 0);
        check_bits("n17_addr1", mem[1], BW'(16));
        check_bits("n17_addr2", mem[2], BW'(15));
        check_bits("n17_addr17", mem[17], BW'(0));
        check_bits("n17_addr18", mem[18], BW'(16));
        check_bits("n17_addr31", mem[31], BW'(3));

        // B = N-1 with N = 2^BW-1: acc+B overflows the word, diff must be chosen.
        run_job(all1 - BW'(1), all1, 0, 0);
        check_bits("ovf_addr1", mem[1], all1 - BW'(1));
        check_bits("ovf_addr2", mem[2], all1 - BW'(2));

        // Fixed large pair.
        run_job({32{32'h1234_5678}}, {32{32'hC3A5_9E17}}, 0, 0);

        for (int s = 0; s < 20; s++) begin
            n = rand_wide();
            if (s % 3 == 1) n = n >> (s * 40);
            n[1] = 1'b1;
            b = rand_wide() % n;
            run_job(b, n, 0, 0);
        end

        // A second start mid-job with other operands must be ignored.
        run_job(BW'(16), BW'(17), 100, 0);
        check_bits("dist_addr31", mem[31], BW'(3));

        // Reset at cycle 200 aborts; a fresh job afterwards is complete and correct.
        run_job({32{32'h0BAD_F00D}}, {32{32'hF00D_CAFE}}, 0, 200);
        run_job(BW'(16), BW'(17), 0, 0);
        check_bits("post_rst_addr18", mem[18], BW'(16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
